jk_mod_counter: RTL and testbench

- Synchronous up/down modulo-N counter whose state bits are JK flip-flop stages.
- It is the downstream consumer of the JK flip-flop cell: it derives per-bit J/K drive from mode inputs and updates each bit with the JK characteristic equation.
- It is used as the lab's reference counter and divider stage.
- It provides parallel load, enable, terminal-count output and a registered wrap pulse.

---
 rtl/jk_mod_counter.sv | 92 +++++++++
 tb/tb_jk_mod_counter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/jk_mod_counter.sv
// Up/down modulo-MODULUS counter built from JK flip-flop stages.
// Every state bit updates only through Q+ = J&~Q | ~K&Q; J/K are decoded from mode inputs.
module jk_mod_counter #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  localparam logic [WIDTH:0]   ModVal = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] j, k;
  logic [WIDTH-1:0] d_sat;
  logic             d_over;
  logic             up_term, dn_term;
  logic             run;
  logic             wrap_q, wrap_d;
  logic             load_err_q, load_err_d;

  assign d_over  = ({1'b0, d} >= ModVal);
  assign d_sat   = d_over ? MaxVal : d;
  // Out-of-range states count as terminal in both directions.
  assign up_term = (q_q >= MaxVal);
  assign dn_term = (q_q == '0) || (q_q > MaxVal);

  always_comb begin
    j          = '0;
    k          = '0;
    run        = 1'b1;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    if (load) begin
      j          = d_sat;
      k          = ~d_sat;
      load_err_d = d_over;
    end else if (en) begin
      if (up) begin
        if (up_term) begin
          k      = '1;
          wrap_d = 1'b1;
        end else begin
          for (int i = 0; i < WIDTH; i++) begin
            j[i] = run;
            k[i] = run;
            run  = run & q_q[i];
          end
        end
      end else begin
        if (dn_term) begin
          j      = MaxVal;
          k      = ~MaxVal;
          wrap_d = 1'b1;
        end else begin
          for (int i = 0; i < WIDTH; i++) begin
            j[i] = run;
            k[i] = run;
            run  = run & ~q_q[i];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q        <= '0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      q_q        <= (j & ~q_q) | (~k & q_q);
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign q        = q_q;
  assign wrap     = wrap_q;
  assign load_err = load_err_q;
  assign tc       = en & ~load & ((up & (q_q == MaxVal)) | (~up & (q_q == '0)));

endmodule

// File: tb/tb_jk_mod_counter.sv
// Bench for jk_mod_counter: three configurations driven in lockstep against an arithmetic model.
module tb_jk_mod_counter;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       en    = 1'b0;
  logic       up    = 1'b1;
  logic       load  = 1'b0;
  logic [3:0] d     = '0;

  logic [3:0] q_a;
  logic [2:0] q_b;
  logic [0:0] q_c;
  logic       tc_a, tc_b, tc_c;
  logic       wrap_a, wrap_b, wrap_c;
  logic       err_a, err_b, err_c;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  jk_mod_counter #(.WIDTH(4), .MODULUS(10)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .d(d),
    .q(q_a), .tc(tc_a), .wrap(wrap_a), .load_err(err_a)
  );

  jk_mod_counter #(.WIDTH(3), .MODULUS(8)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .d(d[2:0]),
    .q(q_b), .tc(tc_b), .wrap(wrap_b), .load_err(err_b)
  );

  jk_mod_counter #(.WIDTH(1), .MODULUS(2)) u_c (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .d(d[0:0]),
    .q(q_c), .tc(tc_c), .wrap(wrap_c), .load_err(err_c)
  );

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain modular arithmetic per instance.
  int mq[3];
  int mw[3];
  int me[3];

  function automatic int modv(input int i);
    return (i == 0) ? 10 : (i == 1) ? 8 : 2;
  endfunction

  function automatic int dval(input int i);
    return (i == 0) ? int'(d) : (i == 1) ? int'(d[2:0]) : int'(d[0]);
  endfunction

  function automatic int mtc(input int i);
    return (en && !load && ((up && mq[i] == modv(i) - 1) || (!up && mq[i] == 0))) ? 1 : 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        mq[i] <= 0;
        mw[i] <= 0;
        me[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (load) begin
          mq[i] <= (dval(i) < modv(i)) ? dval(i) : modv(i) - 1;
          me[i] <= (dval(i) >= modv(i)) ? 1 : 0;
          mw[i] <= 0;
        end else if (en) begin
          me[i] <= 0;
          if (up) begin
            if (mq[i] >= modv(i) - 1) begin
              mq[i] <= 0;
              mw[i] <= 1;
            end else begin
              mq[i] <= mq[i] + 1;
              mw[i] <= 0;
            end
          end else begin
            if (mq[i] == 0 || mq[i] >= modv(i)) begin
              mq[i] <= modv(i) - 1;
              mw[i] <= 1;
            end else begin
              mq[i] <= mq[i] - 1;
              mw[i] <= 0;
            end
          end
        end else begin
          mw[i] <= 0;
          me[i] <= 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("q_a", int'(q_a), mq[0]);
    check("q_b", int'(q_b), mq[1]);
    check("q_c", int'(q_c), mq[2]);
    check("tc_a", int'(tc_a), mtc(0));
    check("tc_b", int'(tc_b), mtc(1));
    check("tc_c", int'(tc_c), mtc(2));
    check("wrap_a", int'(wrap_a), mw[0]);
    check("wrap_b", int'(wrap_b), mw[1]);
    check("wrap_c", int'(wrap_c), mw[2]);
    check("err_a", int'(err_a), me[0]);
    check("err_b", int'(err_b), me[1]);
    check("err_c", int'(err_c), me[2]);
  end

  // Apply inputs, then return 1 time unit after the edge that consumes them.
  task automatic drive(input logic e, input logic u, input logic l, input logic [3:0] dd);
    en   = e;
    up   = u;
    load = l;
    d    = dd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    en = 1'b1;
    up = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_q", int'(q_a), 0);
    check("reset_wrap", int'(wrap_a), 0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("release_q", int'(q_a), 1);

    drive(1'b0, 1'b1, 1'b1, 4'd0);
    repeat (11) drive(1'b1, 1'b1, 1'b0, 4'd0);
    check("up11_a", int'(q_a), 1);
    check("up11_b", int'(q_b), 3);
    check("up11_c", int'(q_c), 1);

    drive(1'b0, 1'b0, 1'b1, 4'd2);
    repeat (3) drive(1'b1, 1'b0, 1'b0, 4'd0);
    check("dn3_a", int'(q_a), 9);
    check("dn3_wrap", int'(wrap_a), 1);
    drive(1'b1, 1'b0, 1'b0, 4'd0);
    check("dn4_a", int'(q_a), 8);
    check("dn4_b", int'(q_b), 6);

    drive(1'b1, 1'b1, 1'b1, 4'd5);
    check("ld5_q", int'(q_a), 5);
    check("ld5_err", int'(err_a), 0);
    drive(1'b0, 1'b1, 1'b1, 4'd12);
    check("ld12_q", int'(q_a), 9);
    check("ld12_err", int'(err_a), 1);
    check("ld12_wrap", int'(wrap_a), 0);
    check("ld12_b", int'(q_b), 4);
    drive(1'b0, 1'b1, 1'b0, 4'd0);
    check("err_pulse", int'(err_a), 0);

    drive(1'b0, 1'b1, 1'b1, 4'd7);
    repeat (3) drive(1'b0, 1'b1, 1'b0, 4'd0);
    check("hold_q", int'(q_a), 7);
    check("hold_tc", int'(tc_a), 0);
    drive(1'b1, 1'b1, 1'b0, 4'd0);
    check("dir_up", int'(q_a), 8);
    drive(1'b1, 1'b0, 1'b0, 4'd0);
    drive(1'b1, 1'b1, 1'b0, 4'd0);
    drive(1'b1, 1'b0, 1'b0, 4'd0);
    check("dir_end", int'(q_a), 7);

    drive(1'b0, 1'b1, 1'b1, 4'd15);
    en   = 1'b1;
    up   = 1'b1;
    load = 1'b0;
    #2;
    check("pre_rst_tc_a", int'(tc_a), 1);
    check("pre_rst_tc_b", int'(tc_b), 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_q_a", int'(q_a), 0);
    check("async_q_b", int'(q_b), 0);
    repeat (2) @(posedge clk);
    #2;
    en    = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_wrap_a", int'(wrap_a), 0);
    check("post_rst_wrap_b", int'(wrap_b), 0);

    repeat (7) drive(1'b1, 1'b1, 1'b0, 4'd0);
    check("b_at7", int'(q_b), 7);
    drive(1'b1, 1'b1, 1'b0, 4'd0);
    check("b_wrap_q", int'(q_b), 0);
    check("b_wrap", int'(wrap_b), 1);

    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      drive(($urandom_range(0, 4) != 0), 1'($urandom), ($urandom_range(0, 7) == 0),
            4'($urandom));
    end
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 4'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
